// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/return sequencer for the single-cycle RV32 core.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_unit #(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic        trap,
    input  logic        is_ebreak,
    input  logic        is_mret,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc_pc,
    output logic        irq_flush
);

    typedef enum logic [2:0] {
        ActNone,
        ActIrq,
        ActTrap,
        ActMret,
        ActWrite
    } action_e;

    localparam logic [31:0] CauseTimer  = 32'h8000_0007;
    localparam logic [31:0] CauseEcall  = 32'd11;
    localparam logic [31:0] CauseEbreak = 32'd3;

    logic                   mstatus_mie_q, mstatus_mie_d;
    logic                   mstatus_mpie_q, mstatus_mpie_d;
    logic                   mie_mtie_q, mie_mtie_d;
    logic [31:2]            mtvec_q, mtvec_d;
    logic [31:2]            mepc_q, mepc_d;
    logic [31:0]            mcause_q, mcause_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic    sync_irq;
    logic    irq_pend;
    action_e act;

    // csr_rd only qualifies the decoder's writeback select; reads are always live.
    logic unused_inputs;
    assign unused_inputs = csr_rd ^ (^pc[1:0]);

    assign sync_irq = sync_q[SYNC_STAGES-1];
    assign irq_pend = sync_irq & mstatus_mie_q & mie_mtie_q;

    always_comb begin
        act = ActNone;
        if (irq_pend) begin
            act = ActIrq;
        end else if (trap) begin
            act = ActTrap;
        end else if (is_mret) begin
            act = ActMret;
        end else if (csr_wr) begin
            act = ActWrite;
        end
    end

    always_comb begin
        epc_taken = 1'b0;
        epc_pc    = 32'h0;
        irq_flush = 1'b0;
        if (!rst) begin
            unique case (act)
                ActIrq: begin
                    irq_flush = 1'b1;
                    epc_taken = 1'b1;
                    epc_pc    = {mtvec_q, 2'b00};
                end
                ActTrap: begin
                    epc_taken = 1'b1;
                    epc_pc    = {mtvec_q, 2'b00};
                end
                ActMret: begin
                    epc_taken = 1'b1;
                    epc_pc    = {mepc_q, 2'b00};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        unique case (act)
            ActIrq, ActTrap: begin
                mepc_d         = pc[31:2];
                mstatus_mpie_d = mstatus_mie_q;
                mstatus_mie_d  = 1'b0;
                if (act == ActIrq) begin
                    mcause_d = CauseTimer;
                end else begin
                    mcause_d = is_ebreak ? CauseEbreak : CauseEcall;
                end
            end
            ActMret: begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
            ActWrite: begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie_d  = csr_wdata[3];
                        mstatus_mpie_d = csr_wdata[7];
                    end
                    12'h304: mie_mtie_d = csr_wdata[7];
                    12'h305: mtvec_d    = csr_wdata[31:2];
                    12'h341: mepc_d     = csr_wdata[31:2];
                    12'h342: mcause_d   = csr_wdata;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST[31:2];
            mepc_q         <= 30'h0;
            mcause_q       <= 32'h0;
            sync_q         <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            sync_q         <= {sync_q[SYNC_STAGES-2:0], timer_irq};
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A write to either half of a counter replaces the increment for that cycle.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = irq_flush ? minstret_q : minstret_q + 64'd1;
        if (act == ActWrite) begin
            case (csr_addr)
                12'hB00: mcycle_d   = {mcycle_q[63:32], csr_wdata};
                12'hB80: mcycle_d   = {csr_wdata, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], csr_wdata};
                12'hB82: minstret_d = {csr_wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            12'h304: csr_rdata = {24'h0, mie_mtie_q, 7'h0};
            12'h305: csr_rdata = {mtvec_q, 2'b00};
            12'h341: csr_rdata = {mepc_q, 2'b00};
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = {24'h0, sync_irq, 7'h0};
`ifdef CSR_COUNTERS_EN
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            12'hB02: csr_rdata = minstret_q[31:0];
            12'hB82: csr_rdata = minstret_q[63:32];
`endif
            default: csr_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: an architectural CSR model checked every cycle, plus directed
// scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_csr_unit;

    localparam int unsigned    S         = 2;
    localparam logic [31:0]    MTVEC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_rd, csr_wr, trap, is_ebreak, is_mret, timer_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc_pc;
    logic        irq_flush;

    int n_cmp = 0;
    int n_bad = 0;

    csr_unit #(
        .MTVEC_RST  (MTVEC_RST),
        .SYNC_STAGES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .csr_addr (csr_addr),
        .csr_wdata(csr_wdata),
        .csr_rd   (csr_rd),
        .csr_wr   (csr_wr),
        .trap     (trap),
        .is_ebreak(is_ebreak),
        .is_mret  (is_mret),
        .timer_irq(timer_irq),
        .csr_rdata(csr_rdata),
        .epc_taken(epc_taken),
        .epc_pc   (epc_pc),
        .irq_flush(irq_flush)
    );

    always #10 clk = ~clk;

    // Architectural model: registers hold exactly what software would read back.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic [7:0]  m_hist;  // timer_irq as sampled on each past edge, newest in bit 0
    logic [63:0] m_cycle, m_instret;
    logic        m_sync, m_pend;

    assign m_sync = m_hist[S-1];
    assign m_pend = m_sync && m_mstatus[3] && m_mie[7];

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_sync ? 32'h80 : 32'h0;
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mstatus <= 32'h0;
            m_mie     <= 32'h0;
            m_mtvec   <= MTVEC_RST & ~32'h3;
            m_mepc    <= 32'h0;
            m_mcause  <= 32'h0;
            m_hist    <= 8'h0;
            m_cycle   <= 64'h0;
            m_instret <= 64'h0;
        end else begin
            m_hist  <= {m_hist[6:0], timer_irq};
            m_cycle <= m_cycle + 64'd1;
            if (!m_pend) m_instret <= m_instret + 64'd1;
            if (m_pend || trap) begin
                m_mepc    <= pc & ~32'h3;
                m_mcause  <= m_pend ? 32'h8000_0007 : (is_ebreak ? 32'd3 : 32'd11);
                m_mstatus <= m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (is_mret) begin
                m_mstatus <= 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (csr_wr) begin
                case (csr_addr)
                    12'h300: m_mstatus <= csr_wdata & 32'h88;
                    12'h304: m_mie     <= csr_wdata & 32'h80;
                    12'h305: m_mtvec   <= csr_wdata & ~32'h3;
                    12'h341: m_mepc    <= csr_wdata & ~32'h3;
                    12'h342: m_mcause  <= csr_wdata;
`ifdef CSR_COUNTERS_EN
                    12'hB00: m_cycle   <= {m_cycle[63:32], csr_wdata};
                    12'hB80: m_cycle   <= {csr_wdata, m_cycle[31:0]};
                    12'hB02: m_instret <= {m_instret[63:32], csr_wdata};
                    12'hB82: m_instret <= {csr_wdata, m_instret[31:0]};
`endif
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_taken", {31'h0, epc_taken}, 32'h0);
                check("rst_flush", {31'h0, irq_flush}, 32'h0);
                check("rst_epc_pc", epc_pc, 32'h0);
                check("rst_rdata", csr_rdata, m_read(csr_addr));
            end else begin
                check("m_rdata", csr_rdata, m_read(csr_addr));
                check("m_taken", {31'h0, epc_taken}, {31'h0, m_pend | trap | is_mret});
                check("m_flush", {31'h0, irq_flush}, {31'h0, m_pend});
                check("m_epc_pc", epc_pc,
                      (m_pend || trap) ? m_mtvec : (is_mret ? m_mepc : 32'h0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wr    = 1'b1;
        tick();
        csr_wr = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        csr_rd   = 1'b1;
        #1;
        check(name, csr_rdata, exp);
        csr_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = 32'h0; csr_addr = 12'h0; csr_wdata = 32'h0;
        csr_rd = 1'b0; csr_wr = 1'b0; trap = 1'b0; is_ebreak = 1'b0;
        is_mret = 1'b0; timer_irq = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        rd("t1_mtvec", 12'h305, 32'h0000_0100);
        rd("t1_mstatus", 12'h300, 32'h0);
        rd("t1_mepc", 12'h341, 32'h0);
        rd("t1_mcause", 12'h342, 32'h0);
        check("t1_taken", {31'h0, epc_taken}, 32'h0);
        tick();

        // Writable-bit masks
        wr(12'h305, 32'h0000_0203);
        rd("t2_mtvec", 12'h305, 32'h0000_0200);
        wr(12'h300, 32'hFFFF_FFFF);
        rd("t2_mstatus", 12'h300, 32'h0000_0088);

        // ECALL then EBREAK
        pc = 32'h40; trap = 1'b1; is_ebreak = 1'b0;
        #1;
        check("t3_taken", {31'h0, epc_taken}, 32'h1);
        check("t3_epc_pc", epc_pc, 32'h200);
        tick();
        trap = 1'b0;
        rd("t3_mepc", 12'h341, 32'h40);
        rd("t3_mcause", 12'h342, 32'd11);
        rd("t3_mstatus", 12'h300, 32'h80);
        wr(12'h300, 32'h8);
        pc = 32'h48; trap = 1'b1; is_ebreak = 1'b1;
        tick();
        trap = 1'b0; is_ebreak = 1'b0;
        rd("t3_mcause_eb", 12'h342, 32'd3);
        rd("t3_mepc_eb", 12'h341, 32'h48);

        // Timer interrupt after S synchroniser edges; coincident write is dropped
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        pc = 32'h60; timer_irq = 1'b1;
        #1;
        check("t4_flush_e0", {31'h0, irq_flush}, 32'h0);
        tick();
        check("t4_flush_e1", {31'h0, irq_flush}, 32'h0);
        tick();
        pc = 32'h64; csr_addr = 12'h342; csr_wdata = 32'h1234; csr_wr = 1'b1;
        #1;
        check("t4_flush_e2", {31'h0, irq_flush}, 32'h1);
        check("t4_epc_pc", epc_pc, 32'h200);
        check("t4_old_mcause", csr_rdata, 32'd3);
        tick();
        csr_wr = 1'b0;
        rd("t4_mcause", 12'h342, 32'h8000_0007);
        rd("t4_mepc", 12'h341, 32'h64);
        rd("t4_mstatus", 12'h300, 32'h80);
        rd("t4_mip", 12'h344, 32'h80);

        // MRET, then the still-pending timer is retaken
        wr(12'h341, 32'h44);
        is_mret = 1'b1;
        #1;
        check("t5_epc_pc", epc_pc, 32'h44);
        check("t5_flush_mret", {31'h0, irq_flush}, 32'h0);
        tick();
        is_mret = 1'b0;
        rd("t5_mstatus", 12'h300, 32'h88);
        check("t5_retake", {31'h0, irq_flush}, 32'h1);
        tick();

        // Write MIE=1 with the timer pending: interrupt one cycle later
        csr_addr = 12'h300; csr_wdata = 32'h8; csr_wr = 1'b1;
        #1;
        check("wi_same_cycle", {31'h0, irq_flush}, 32'h0);
        tick();
        csr_wr = 1'b0;
        #1;
        check("wi_next_cycle", {31'h0, irq_flush}, 32'h1);
        tick();
        timer_irq = 1'b0;
        repeat (S + 1) tick();
        rd("mip_clear", 12'h344, 32'h0);

        // Unmapped addresses
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd("unmapped", 12'h7C0, 32'h0);

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        tick();
        tick();
        rd("t6_mcycleh", 12'hB80, 32'h1);
        rd("t6_mcycle", 12'hB00, 32'h1);
        wr(12'hB02, 32'h0);
        wr(12'hB82, 32'h0);
        csr_addr = 12'hB02;
        repeat (3) tick();
        rd("t6_minstret3", 12'hB02, 32'd3);
        tick();
        timer_irq = 1'b1;
        wr(12'h300, 32'h8);
        tick();
        #1;
        check("t6_flush", {31'h0, irq_flush}, 32'h1);
        tick();
        rd("t6_minstret6", 12'hB02, 32'd6);
        timer_irq = 1'b0;
        repeat (S + 1) tick();
`else
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("nocnt_mcycle", 12'hB00, 32'h0);
`endif

        // Reset in the middle of a trap cycle
        wr(12'h341, 32'h1000);
        pc = 32'h80; trap = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_taken", {31'h0, epc_taken}, 32'h0);
        tick();
        trap = 1'b0;
        rst = 1'b0;
        rd("rst_mid_mtvec", 12'h305, 32'h100);
        rd("rst_mid_mepc", 12'h341, 32'h0);
        rd("rst_mid_mcause", 12'h342, 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
